rr_mux_nx1: RTL and testbench
=============================

// Module: rr_mux_nx1
// PURPOSE
//  N-channel, W-bit round-robin multiplexer with valid/ready handshake and a
//  registered output stage. Successor to the plain 2:1 select mux: selection is
//  made by a fair arbiter instead of an external sel. PKT_MODE holds the grant
//  for a multi-beat packet. Sits between several producers and one shared
//  consumer (bus, FIFO, UART TX).
// PARAMETERS
//  N         4  number of input channels, N >= 2
//  W         8  data width per channel, W >= 1
//  PKT_MODE  0  0 = re-arbitrate every beat; 1 = hold grant until in_last beat
//  SELW      $clog2(N)  width of out_sel (derived, not overridden)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   N      per-channel beat valid
//  in_data    in   N*W    channel i data at [i*W +: W]
//  in_last    in   N      per-channel last-beat flag
//  in_ready   out  N      per-channel accept; at most one bit set
//  out_valid  out  1      output register holds a beat
//  out_data   out  W      registered data of selected channel
//  out_last   out  1      registered in_last of selected beat
//  out_sel    out  SELW   index of channel that supplied current beat
//  out_ready  in   1      consumer accepts output beat
// BEHAVIOUR
//  - One clock, clk. rst asynchronous, active-high. Reset: out_valid=0,
//    out_data=0, out_last=0, out_sel=0, ptr=0, lock=0.
//  - Reset mid-packet: lock cleared. The partially sent packet is abandoned.
//  - load = !out_valid | out_ready. Output register accepts a beat only when load=1.
//    A register drained and refilled in the same cycle sustains full throughput.
//  - Arbitration (comb.), lock=0: grant = first i with in_valid[i]=1, scanning
//    ptr, ptr+1, ... N-1, 0, ... ptr-1. No valid -> no grant.
//  - lock=1: grant = locked channel only, and only while its in_valid=1.
//    Other channels wait even if valid.
//  - in_ready[i] = load & grant==i. This path is combinational from in_valid,
//    out_valid and out_ready. in_ready is 0 for non-granted channels.
//  - Transfer on channel g when in_valid[g] & in_ready[g]. Next edge:
//    out_data=in_data[g], out_last=in_last[g], out_sel=g, out_valid=1.
//  - Latency: input beat to out_valid is exactly 1 cycle.
//  - load=1 with no transfer: out_valid <= 0.
//  - load=0: the output register holds all values stable (AXI-style).
//  - Pointer: on each transfer, ptr <= (g==N-1) ? 0 : g+1. Wrap-around is
//    explicit, so N need not be a power of 2. Without a transfer, ptr holds.
//  - PKT_MODE=1, transfer with in_last=0: lock<=1 and locked channel <= g.
//  - PKT_MODE=1, transfer with in_last=1: lock<=0.
//  - While locked, ptr is still updated per beat. Fairness therefore resumes
//    after the packet at g+1.
//  - PKT_MODE=0: lock is constant 0. in_last is passed through only.
//  - Producers must hold in_data/in_last stable while in_valid=1 & in_ready=0.
//  - Single-channel traffic: a lone requester gets every beat back-to-back,
//    with no idle cycle.
//  - Backpressure and request in the same cycle (out_valid=1, out_ready=0,
//    in_valid!=0): in_ready=0. No state changes.
// TESTING  (N=4, W=8 unless noted)
//  1. Reset while out_valid=1, lock=1 -> all outputs 0 asynchronously, before
//     the next edge. After release, ch0 data 8'hA5 appears with out_sel=0
//     one cycle later.
//  2. in_valid=4'b1111, out_ready=1, PKT_MODE=0, data ch i = 8'h10+i ->
//     out_sel sequence 0,1,2,3,0,... and out_data 10,11,12,13,10. One beat
//     per cycle.
//  3. out_valid=1 holding 8'h12, out_ready=0 for 3 cycles -> out_data/out_sel
//     stable and in_ready=0. On the next cycle with out_ready=1, the next
//     winner is loaded in that same cycle.
//  4. PKT_MODE=1, ch1 sends 3 beats (last on 3rd) while ch2 valid throughout ->
//     out_sel=1,1,1 then 2. ch2 in_ready=0 until the ch1 last beat transfers.
//  5. Only ch3 valid, then ch0 and ch3 valid -> after the ch3 beat, ptr wraps
//     to 0 and ch0 wins next. Check with N=3: ptr wraps 2->0, never reaches 3.
//  6. Random valid/ready for 10k cycles, scoreboard per channel ->
//     - in-order data, no loss or duplication
//     - at most one in_ready set in any cycle
//     - no channel starved longer than N-1 grants (PKT_MODE=0)

Source files
------------

// File: rtl/rr_mux_nx1.sv
// N-channel round-robin multiplexer with valid/ready handshake and a registered output stage.
// PKT_MODE=1 keeps the grant on one channel until its in_last beat has transferred.
module rr_mux_nx1 #(
    parameter int unsigned  N        = 4,
    parameter int unsigned  W        = 8,
    parameter int unsigned  PKT_MODE = 0,
    localparam int unsigned SELW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t          r_state;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] r_lock_ch;

    logic            w_load;
    logic            w_xfer;
    logic            w_gnt_vld;
    logic [SELW-1:0] w_gnt;
    logic [SELW:0]   w_cand;
    logic [W-1:0]    w_gnt_data;
    logic            w_gnt_last;

    assign w_load = !out_valid || out_ready;
    assign w_xfer = w_load && w_gnt_vld;

    // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-2 N never indexes past N-1.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_cand    = '0;
        if (r_state == ST_LOCK) begin
            w_gnt_vld = in_valid[r_lock_ch];
            w_gnt     = r_lock_ch;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                w_cand = {1'b0, r_ptr} + (SELW+1)'(i);
                if (w_cand >= (SELW+1)'(N)) begin
                    w_cand = w_cand - (SELW+1)'(N);
                end
                if (!w_gnt_vld && in_valid[w_cand[SELW-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = w_cand[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gnt == SELW'(i)) begin
                w_gnt_data  = in_data[i*W +: W];
                w_gnt_last  = in_last[i];
                in_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            r_ptr     <= '0;
            r_state   <= ST_ARB;
            r_lock_ch <= '0;
        end else begin
            if (w_load) begin
                out_valid <= w_xfer;
                if (w_xfer) begin
                    out_data <= w_gnt_data;
                    out_last <= w_gnt_last;
                    out_sel  <= w_gnt;
                end
            end
            if (w_xfer) begin
                r_ptr <= (w_gnt == SELW'(N-1)) ? '0 : w_gnt + 1'b1;
                if (PKT_MODE != 0) begin
                    r_state   <= w_gnt_last ? ST_ARB : ST_LOCK;
                    r_lock_ch <= w_gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Scoreboard bench for rr_mux_nx1: three instances (N=4 per-beat, N=4 packet mode, N=3 per-beat).
// Stimulus pushes expected beats; a negedge monitor pops and compares on each output handshake.
module tb_rr_mux_nx1;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [1:0] s;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv   [3];
    logic [31:0] idat [3];
    logic [3:0]  ilst [3];
    logic        ordy [3];

    logic [3:0]  ir_a, ir_b;
    logic [2:0]  ir_c;
    logic        ov_a, ov_b, ov_c;
    logic [7:0]  od_a, od_b, od_c;
    logic        ol_a, ol_b, ol_c;
    logic [1:0]  os_a, os_b, os_c;

    logic [3:0]  irdy [3];
    logic        ovl  [3];
    logic [7:0]  odat [3];
    logic        olst [3];
    logic [1:0]  osel [3];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pop_cnt [3];
    bit          rnd = 1'b0;
    beat_t       exp_q [3][$];
    beat_t       chq [4][$];
    beat_t       mon_e;
    logic [3:0]  xm;
    int          seq [4];
    int          waitc [4];
    int          maxw [4];

    always #5 clk = ~clk;

    always_comb begin
        irdy[0] = ir_a;  irdy[1] = ir_b;  irdy[2] = {1'b0, ir_c};
        ovl[0]  = ov_a;  ovl[1]  = ov_b;  ovl[2]  = ov_c;
        odat[0] = od_a;  odat[1] = od_b;  odat[2] = od_c;
        olst[0] = ol_a;  olst[1] = ol_b;  olst[2] = ol_c;
        osel[0] = os_a;  osel[1] = os_b;  osel[2] = os_c;
    end

    rr_mux_nx1 #(.N(4), .W(8), .PKT_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_last(ilst[0]),
        .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_last(ol_a),
        .out_sel(os_a), .out_ready(ordy[0])
    );

    rr_mux_nx1 #(.N(4), .W(8), .PKT_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]), .in_last(ilst[1]),
        .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .out_last(ol_b),
        .out_sel(os_b), .out_ready(ordy[1])
    );

    rr_mux_nx1 #(.N(3), .W(8), .PKT_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_data(idat[2][23:0]), .in_last(ilst[2][2:0]),
        .in_ready(ir_c), .out_valid(ov_c), .out_data(od_c), .out_last(ol_c),
        .out_sel(os_c), .out_ready(ordy[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t bt(input logic [7:0] d, input logic l, input logic [1:0] s);
        return {d, l, s};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a beat is consumed at the next posedge whenever out_valid & out_ready here.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (ovl[k] && ordy[k]) begin
                    pop_cnt[k]++;
                    if (rnd && k == 0) begin
                        if (chq[osel[0]].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rnd_extra: unexpected beat %0h from ch%0d", odat[0], osel[0]);
                        end else begin
                            mon_e = chq[osel[0]].pop_front();
                            chk("rnd_beat", {odat[0], olst[0], osel[0]}, mon_e);
                        end
                    end else if (exp_q[k].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_beat_dut%0d: got %0h sel %0d, expected none", k, odat[k], osel[k]);
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        chk($sformatf("beat_dut%0d", k), {odat[k], olst[k], osel[k]}, mon_e);
                    end
                end
            end
        end
    end

    task automatic rnd_cycle(input bit allow);
        logic [7:0] d;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (xm[i]) iv[0][i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (allow && !iv[0][i] && $urandom_range(0, 2) != 0) begin
                seq[i]++;
                d = {2'(i), 6'(seq[i])};
                idat[0][i*8 +: 8] = d;
                ilst[0][i] = seq[i][0];
                iv[0][i] = 1'b1;
                chq[i].push_back(bt(d, seq[i][0], 2'(i)));
            end
        end
        ordy[0] = allow ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        xm = iv[0] & irdy[0];
        chk("onehot_ready", $countones(irdy[0]) <= 1, 1);
        for (int i = 0; i < 4; i++) begin
            if (xm[i]) begin
                waitc[i] = 0;
            end else if (iv[0][i] && xm != 0) begin
                waitc[i]++;
                if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        xm  = '0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; idat[k] = '0; ilst[k] = '0; ordy[k] = 1'b1; pop_cnt[k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0; waitc[i] = 0; maxw[i] = 0;
        end
        cyc(2);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), ovl[k], 0);
            chk($sformatf("rst_data%0d", k), odat[k], 0);
            chk($sformatf("rst_last%0d", k), olst[k], 0);
            chk($sformatf("rst_sel%0d", k), osel[k], 0);
        end
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // All four valid: strict rotation, one beat per cycle.
        idat[0] = 32'h13121110;
        iv[0]   = 4'hF;
        exp_q[0].push_back(bt(8'h10, 0, 0));
        exp_q[0].push_back(bt(8'h11, 0, 1));
        exp_q[0].push_back(bt(8'h12, 0, 2));
        exp_q[0].push_back(bt(8'h13, 0, 3));
        exp_q[0].push_back(bt(8'h10, 0, 0));
        cyc(5);
        iv[0] = '0;
        #3;
        chk("t2_rate", pop_cnt[0], 5);
        cyc(2);

        // Lone ch3, then ch0+ch3: pointer wraps to 0 after ch3.
        idat[0] = 32'h33000000;
        iv[0]   = 4'b1000;
        exp_q[0].push_back(bt(8'h33, 0, 3));
        cyc(1);
        idat[0] = 32'h34000030;
        iv[0]   = 4'b1001;
        exp_q[0].push_back(bt(8'h30, 0, 0));
        exp_q[0].push_back(bt(8'h34, 0, 3));
        cyc(1);
        iv[0] = 4'b1000;
        cyc(1);
        iv[0] = '0;
        cyc(2);

        // Backpressure with pending requests, then release.
        idat[0] = 32'h00120000;
        iv[0]   = 4'b0100;
        ordy[0] = 1'b0;
        exp_q[0].push_back(bt(8'h12, 0, 2));
        cyc(1);
        idat[0] = 32'h00002120;
        iv[0]   = 4'b0011;
        exp_q[0].push_back(bt(8'h20, 0, 0));
        exp_q[0].push_back(bt(8'h21, 0, 1));
        repeat (3) begin
            #3;
            chk("t3_hold_data", odat[0], 8'h12);
            chk("t3_hold_sel", osel[0], 2);
            chk("t3_hold_valid", ovl[0], 1);
            chk("t3_no_ready", irdy[0], 4'b0000);
            cyc(1);
        end
        ordy[0] = 1'b1;
        #1;
        chk("t3_resume_ready", irdy[0], 4'b0001);
        cyc(1);
        iv[0] = 4'b0010;
        cyc(1);
        iv[0] = '0;
        cyc(2);

        // Packet mode: ch1 three-beat packet holds the grant against ch2.
        idat[1] = 32'h00504100;
        ilst[1] = 4'b0100;
        iv[1]   = 4'b0110;
        exp_q[1].push_back(bt(8'h41, 0, 1));
        exp_q[1].push_back(bt(8'h42, 0, 1));
        exp_q[1].push_back(bt(8'h43, 1, 1));
        exp_q[1].push_back(bt(8'h50, 1, 2));
        #1;
        chk("t4_ready_b1", irdy[1], 4'b0010);
        cyc(1);
        idat[1][15:8] = 8'h42;
        #1;
        chk("t4_ready_b2", irdy[1], 4'b0010);
        cyc(1);
        idat[1][15:8] = 8'h43;
        ilst[1][1]    = 1'b1;
        #1;
        chk("t4_ready_b3", irdy[1], 4'b0010);
        cyc(1);
        iv[1] = 4'b0100;
        #1;
        chk("t4_ready_ch2", irdy[1], 4'b0100);
        cyc(1);
        iv[1]   = '0;
        ilst[1] = '0;
        cyc(2);

        // Asynchronous reset mid-packet with a held output beat.
        idat[1] = 32'h00006100;
        iv[1]   = 4'b0010;
        ordy[1] = 1'b0;
        cyc(1);
        iv[1] = '0;
        #1;
        chk("t1_pre_valid", ovl[1], 1);
        chk("t1_pre_data", odat[1], 8'h61);
        rst = 1'b1;
        #1;
        chk("t1_rst_valid", ovl[1], 0);
        chk("t1_rst_data", odat[1], 0);
        chk("t1_rst_sel", osel[1], 0);
        chk("t1_rst_last", olst[1], 0);
        cyc(1);
        rst     = 1'b0;
        idat[1] = 32'h000000A5;
        ilst[1] = 4'b0001;
        iv[1]   = 4'b0001;
        ordy[1] = 1'b1;
        exp_q[1].push_back(bt(8'hA5, 1, 0));
        cyc(1);
        iv[1] = '0;
        #1;
        chk("t1_after_valid", ovl[1], 1);
        chk("t1_after_data", odat[1], 8'hA5);
        chk("t1_after_sel", osel[1], 0);
        cyc(2);

        // N=3: pointer wraps 2 -> 0.
        idat[2] = 32'h00720000;
        iv[2]   = 4'b0100;
        exp_q[2].push_back(bt(8'h72, 0, 2));
        cyc(1);
        idat[2] = 32'h00007170;
        iv[2]   = 4'b0011;
        exp_q[2].push_back(bt(8'h70, 0, 0));
        exp_q[2].push_back(bt(8'h71, 0, 1));
        cyc(1);
        iv[2] = 4'b0010;
        cyc(1);
        idat[2] = 32'h00820080;
        iv[2]   = 4'b0101;
        exp_q[2].push_back(bt(8'h82, 0, 2));
        exp_q[2].push_back(bt(8'h80, 0, 0));
        cyc(1);
        iv[2] = 4'b0001;
        cyc(1);
        iv[2] = '0;
        cyc(2);

        // Random traffic on the N=4 per-beat instance, per-channel ordering.
        rnd = 1'b1;
        for (int c = 0; c < 10000; c++) rnd_cycle(c < 9900);
        for (int c = 0; c < 50; c++) rnd_cycle(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("starve_ch%0d", i), maxw[i] <= 3, 1);
            chk($sformatf("rnd_drained_ch%0d", i), chq[i].size(), 0);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drained_dut%0d", k), exp_q[k].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
